// File: rtl/midori64_ti_pkg.sv
// Shared definitions for the 3-share Midori64 Q299 layer.
// - Width constants for nibbles, the full state and the share count.
// - FSM state encoding used by the layer pipe.
// - q_share: one cyclic component of the shared Q299 nibble function.
//   It is a function of exactly two shares (i and i+1).
// - q_ref: the unshared Q299 nibble function, used as a reference model.
package midori64_ti_pkg;

  localparam int NIB_W   = 4;
  localparam int STATE_W = 64;
  localparam int NSHARE  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Shared AND term for output share i: a_i b_i ^ a_i b_j ^ a_j b_i.
  // XOR over all three cyclic shares covers all nine cross products.
  function automatic logic sh_and(input logic a_i, input logic b_i,
                                  input logic a_j, input logic b_j);
    return (a_i & b_i) ^ (a_i & b_j) ^ (a_j & b_i);
  endfunction

  function automatic logic [3:0] q_share(input logic [3:0] xi, input logic [3:0] xj);
    logic [3:0] y;
    y[3] = xi[3];
    y[2] = xi[2] ^ sh_and(xi[1], xi[3], xj[1], xj[3])
                 ^ sh_and(xi[2], xi[3], xj[2], xj[3]);
    y[1] = xi[1] ^ sh_and(xi[0], xi[3], xj[0], xj[3])
                 ^ sh_and(xi[1], xi[3], xj[1], xj[3])
                 ^ sh_and(xi[2], xi[3], xj[2], xj[3]);
    y[0] = xi[0] ^ sh_and(xi[0], xi[3], xj[0], xj[3])
                 ^ sh_and(xi[2], xi[3], xj[2], xj[3]);
    return y;
  endfunction

  function automatic logic [3:0] q_ref(input logic [3:0] x);
    logic [3:0] y;
    y[3] = x[3];
    y[2] = x[2] ^ (x[1] & x[3]) ^ (x[2] & x[3]);
    y[1] = x[1] ^ (x[0] & x[3]) ^ (x[1] & x[3]) ^ (x[2] & x[3]);
    y[0] = x[0] ^ (x[0] & x[3]) ^ (x[2] & x[3]);
    return y;
  endfunction

endpackage

// File: rtl/midori64_q299_layer_pipe_q299_nibble_ti.sv
// q299_nibble_ti: one nibble of the 3-share Q299 layer, purely combinational.
// Ports:
//   x1, x2, x3 : input shares of one nibble
//   y1, y2, y3 : output shares; y_i depends only on x_i and x_(i+1 mod 3)
module q299_nibble_ti
  import midori64_ti_pkg::*;
(
  input  logic [NIB_W-1:0] x1,
  input  logic [NIB_W-1:0] x2,
  input  logic [NIB_W-1:0] x3,
  output logic [NIB_W-1:0] y1,
  output logic [NIB_W-1:0] y2,
  output logic [NIB_W-1:0] y3
);

  assign y1 = q_share(x1, x2);
  assign y2 = q_share(x2, x3);
  assign y3 = q_share(x3, x1);

endmodule

// File: rtl/midori64_q299_layer_pipe.sv
// midori64_q299_layer_pipe: applies the shared Q299 nibble layer ITER times to a
// 3-share 64-bit state, registering the shares after each application.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake, in_s1..in_s3 input shares
//   out_valid / out_ready: output handshake, out_s1..out_s3 result shares
//   busy                 : high while Q applications are in progress
//   dbg_state            : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// output shares are held stable until out_ready is seen. All handshake outputs
// are registered, so no input reaches an output combinationally.
module midori64_q299_layer_pipe
  import midori64_ti_pkg::*;
#(
  parameter int ITER = 2,
  parameter int NIB  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  in_s1,
  input  logic [4*NIB-1:0]  in_s2,
  input  logic [4*NIB-1:0]  in_s3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  out_s1,
  output logic [4*NIB-1:0]  out_s2,
  output logic [4*NIB-1:0]  out_s3,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int W = NIB * NIB_W;
  localparam logic [2:0] LAST = 3'(ITER - 1);

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   q1, q2, q3;

  // One Q layer step from the current share registers.
  for (genvar n = 0; n < NIB; n++) begin : g_nib
    q299_nibble_ti u_ti (
      .x1 (s1_q[n*NIB_W +: NIB_W]),
      .x2 (s2_q[n*NIB_W +: NIB_W]),
      .x3 (s3_q[n*NIB_W +: NIB_W]),
      .y1 (q1[n*NIB_W +: NIB_W]),
      .y2 (q2[n*NIB_W +: NIB_W]),
      .y3 (q3[n*NIB_W +: NIB_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s1_d    = in_s1;
          s2_d    = in_s2;
          s3_d    = in_s3;
          cnt_d   = 3'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s1_d  = q1;
        s2_d  = q2;
        s3_d  = q3;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are decoded from the next state so they are registered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_s1    = s1_q;
  assign out_s2    = s2_q;
  assign out_s3    = s3_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_midori64_q299_layer_pipe.sv
// Bench for midori64_q299_layer_pipe: two instances, index 0 with ITER=1 and
// index 1 with ITER=2, each with its own stimulus signals.
module tb_midori64_q299_layer_pipe;
  import midori64_ti_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        in_valid[2];
  logic        in_ready[2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        busy[2];
  logic [63:0] in_s1[2], in_s2[2], in_s3[2];
  logic [63:0] out_s1[2], out_s2[2], out_s3[2];
  state_e      dbg_state[2];

  midori64_q299_layer_pipe #(.ITER(1), .NIB(16)) dut1 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_s1(in_s1[0]), .in_s2(in_s2[0]), .in_s3(in_s3[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_s1(out_s1[0]), .out_s2(out_s2[0]), .out_s3(out_s3[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  midori64_q299_layer_pipe #(.ITER(2), .NIB(16)) dut2 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_s1(in_s1[1]), .in_s2(in_s2[1]), .in_s3(in_s3[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_s1(out_s1[1]), .out_s2(out_s2[1]), .out_s3(out_s3[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] q_model(input logic [63:0] x, input int iters);
    logic [63:0] r;
    logic [3:0]  v;
    for (int k = 0; k < 16; k++) begin
      v = x[4*k +: 4];
      for (int t = 0; t < iters; t++) v = q_ref(v);
      r[4*k +: 4] = v;
    end
    return r;
  endfunction

  function automatic logic [63:0] out_xor(input int d);
    return out_s1[d] ^ out_s2[d] ^ out_s3[d];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
  endtask

  // Full transaction: wait for in_ready, capture, check latency and BUSY
  // length, return the XOR of the result shares, then release with out_ready.
  task automatic run_txn(input int d, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, output logic [63:0] x);
    int lat;
    int busy_cnt;
    int w;
    w = 0;
    while (!in_ready[d] && w < 20) begin
      tick();
      w++;
    end
    in_s1[d] = a;
    in_s2[d] = b;
    in_s3[d] = c;
    in_valid[d] = 1'b1;
    tick();                     // capture edge
    in_valid[d] = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid[d] && lat < 20) begin
      if (busy[d]) busy_cnt++;
      tick();
      lat++;
    end
    chk($sformatf("latency_d%0d", d), 64'(lat), 64'(d + 1));
    chk($sformatf("busy_len_d%0d", d), 64'(busy_cnt), 64'(d + 1));
    x = out_xor(d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk($sformatf("idle_after_d%0d", d), {62'd0, in_ready[d], out_valid[d]}, 64'd2);
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] x, r1, r2, held1, held2, held3;
  int          stable_bad, stale, got_n, last_t, t;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      in_s1[d] = '0; in_s2[d] = '0; in_s3[d] = '0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ctrl_d%0d", d),
          {61'd0, in_ready[d], out_valid[d], busy[d]}, 64'd4);
      chk($sformatf("rst_s1_d%0d", d), out_s1[d], 64'd0);
      chk($sformatf("rst_s2_d%0d", d), out_s2[d], 64'd0);
      chk($sformatf("rst_s3_d%0d", d), out_s3[d], 64'd0);
    end

    // Zero state, ITER=2
    run_txn(1, 64'd0, 64'd0, 64'd0, x);
    chk("zero_xor", x, 64'd0);
    chk("zero_s1", out_s1[1], 64'd0);

    // All-ones unshared value
    run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, x);
    chk("ones_iter1", x, 64'hDDDD_DDDD_DDDD_DDDD);
    run_txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, x);
    chk("ones_iter2", x, 64'h9999_9999_9999_9999);

    // Random masks over a fixed unshared value, ITER=1
    for (int i = 0; i < 1000; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      run_txn(0, r1, r2, 64'hCCCC_8888_7777_0000 ^ r1 ^ r2, x);
      chk("mask_iter1", x, 64'hBBBB_8888_7777_0000);
    end

    // Random unshared values on both instances against the reference model
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        held3 = {$urandom(), $urandom()};
        run_txn(d, r1, r2, held3, x);
        chk($sformatf("model_d%0d", d), x, q_model(r1 ^ r2 ^ held3, d + 1));
      end
    end

    // Backpressure on ITER=2
    in_s1[1] = 64'h0123_4567_89AB_CDEF; in_s2[1] = 64'h1111_2222_3333_4444;
    in_s3[1] = 64'h5555_6666_7777_8888;
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    t = 0;
    while (!out_valid[1] && t < 20) begin
      tick();
      t++;
    end
    chk("bp_latency", 64'(t), 64'd2);
    held1 = out_s1[1]; held2 = out_s2[1]; held3 = out_s3[1];
    chk("bp_result", held1 ^ held2 ^ held3,
        q_model(64'h0123_4567_89AB_CDEF ^ 64'h1111_2222_3333_4444 ^ 64'h5555_6666_7777_8888, 2));
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = i[0];
      in_s1[1] = {$urandom(), $urandom()};
      tick();
      if (!out_valid[1] || in_ready[1] || out_s1[1] !== held1 ||
          out_s2[1] !== held2 || out_s3[1] !== held3) stable_bad++;
    end
    chk("bp_stable", 64'(stable_bad), 64'd0);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("bp_release", {62'd0, in_ready[1], out_valid[1]}, 64'd2);
    run_txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, x);
    chk("bp_next", x, 64'h9999_9999_9999_9999);

    // Reset one cycle after capture on ITER=2
    in_s1[1] = 64'hDEAD_BEEF_CAFE_F00D; in_s2[1] = 64'h1; in_s3[1] = 64'h2;
    in_valid[1] = 1'b1;
    tick();                     // capture
    in_valid[1] = 1'b0;
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("rb_ctrl", {61'd0, in_ready[1], out_valid[1], busy[1]}, 64'd4);
    chk("rb_s1", out_s1[1], 64'd0);
    chk("rb_s2", out_s2[1], 64'd0);
    chk("rb_s3", out_s3[1], 64'd0);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[1]) stale++;
    end
    chk("rb_no_stale", 64'(stale), 64'd0);

    // Back-to-back on ITER=2: in_valid and out_ready held high
    out_ready[1] = 1'b1;
    got_n = 0;
    last_t = -1;
    t = 0;
    while (got_n < 5 && t < 60) begin
      if (out_valid[1]) begin
        chk("b2b_result", out_xor(1), (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx);
        if (last_t >= 0) chk("b2b_period", 64'(t - last_t), 64'd4);
        last_t = t;
        got_n++;
      end
      if (in_ready[1]) begin
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        in_s1[1] = r1; in_s2[1] = r2; in_s3[1] = 64'(t) * 64'h0101_0101_0101_0101;
        exp_q.push_back(q_model(r1 ^ r2 ^ in_s3[1], 2));
        in_valid[1] = 1'b1;
      end
      tick();
      t++;
    end
    chk("b2b_count", 64'(got_n), 64'd5);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    reset_dut(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
